// File: rtl/inst_queue_pkg.sv
// Shared widths and entry layout for the instruction queue between fetch and decode.
package inst_queue_pkg;

  localparam int unsigned INST_WIDTH           = 32;
  localparam int unsigned INST_ADDR_WIDTH      = 32;
  localparam int unsigned INST_QUEUE_DEPTH     = 8;
  localparam int unsigned INST_QUEUE_PTR_WIDTH = 3;

  // One queued instruction together with its fetch PC
  typedef struct packed {
    logic [INST_WIDTH-1:0]      inst;
    logic [INST_ADDR_WIDTH-1:0] pc;
  } entry_t;

endpackage

// File: rtl/inst_queue.sv
// 8-entry circular instruction queue decoupling fetch from decode.
// Optional INST_QUEUE_BYPASS_EN forwards an offer straight to decode when the queue is empty.
module inst_queue
  import inst_queue_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fetch_write,
  input  logic [INST_WIDTH-1:0]           fetch_inst,
  input  logic [INST_ADDR_WIDTH-1:0]      fetch_pc,
  output logic                            fetch_stall,
  output logic [INST_WIDTH-1:0]           inst_in,
  output logic [INST_ADDR_WIDTH-1:0]      inst_pc,
  output logic                            inst_enable,
  input  logic                            inst_stall,
  input  logic                            clear,
  output logic [INST_QUEUE_PTR_WIDTH:0]   count
);

  localparam int unsigned PTR_W = INST_QUEUE_PTR_WIDTH;
  localparam int unsigned CNT_W = INST_QUEUE_PTR_WIDTH + 1;

  entry_t           mem [INST_QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             not_empty;
  logic             bypass_hit;
  logic             push;
  logic             pop;
  entry_t           head_entry;

  assign head_entry = mem[head];
  assign not_empty  = (count != '0);

  // Full is judged on registered occupancy only; a same-cycle pop does not free a slot
  always_comb begin
    fetch_stall = (count == CNT_W'(INST_QUEUE_DEPTH));
    bypass_hit  = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass_hit  = !not_empty && fetch_write && !inst_stall && !clear;
`endif
    pop         = not_empty && !inst_stall && !clear;
    push        = fetch_write && !fetch_stall && !clear && !bypass_hit;
    inst_enable = pop || bypass_hit;
    inst_in     = '0;
    inst_pc     = '0;
    if (bypass_hit) begin
      inst_in = fetch_inst;
      inst_pc = fetch_pc;
    end else if (not_empty) begin
      inst_in = head_entry.inst;
      inst_pc = head_entry.pc;
    end
  end

  // Pointers and occupancy; reset outranks clear, clear outranks push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; stale contents are never visible because count gates the read
  always_ff @(posedge clk) begin
    if (!rst && push) mem[tail] <= '{inst: fetch_inst, pc: fetch_pc};
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed scenarios followed by random traffic.
module tb_inst_queue;

  logic        clk;
  logic        rst;
  logic        fetch_write;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic [31:0] inst_in;
  logic [31:0] inst_pc;
  logic        inst_enable;
  logic        inst_stall;
  logic        clear;
  logic [3:0]  count;

  int errors = 0;
  int checks = 0;

  logic [63:0] sb [$];
  int          n;
  logic        byp;
  logic        exp_en;

  inst_queue dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_write (fetch_write),
    .fetch_inst  (fetch_inst),
    .fetch_pc    (fetch_pc),
    .fetch_stall (fetch_stall),
    .inst_in     (inst_in),
    .inst_pc     (inst_pc),
    .inst_enable (inst_enable),
    .inst_stall  (inst_stall),
    .clear       (clear),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs come from the scoreboard contents; the queue is updated as the edge would
  always @(negedge clk) begin
    n   = sb.size();
    byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    byp = (n == 0) && fetch_write && !inst_stall && !clear;
`endif
    exp_en = ((n != 0) && !inst_stall && !clear) || byp;
    check("count", 64'(count), 64'(n));
    check("fetch_stall", 64'(fetch_stall), 64'(n == 8));
    check("inst_enable", 64'(inst_enable), 64'(exp_en));
    if (byp)
      check("bypass_out", {inst_in, inst_pc}, {fetch_inst, fetch_pc});
    else if (n == 0)
      check("empty_out", {inst_in, inst_pc}, 64'd0);
    else
      check("head", {inst_in, inst_pc}, sb[0]);
    if (rst || clear) begin
      sb.delete();
    end else begin
      if (n != 0 && !inst_stall) void'(sb.pop_front());
      if (fetch_write && n != 8 && !byp) sb.push_back({fetch_inst, fetch_pc});
    end
  end

  task automatic step(input logic fw, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic clr);
    fetch_write = fw;
    fetch_inst  = ins;
    fetch_pc    = pc;
    inst_stall  = st;
    clear       = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    fetch_write = 1'b0; fetch_inst = '0; fetch_pc = '0; inst_stall = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);

    // single instruction, latency check
    step(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    idle(2);

    // stall fill with 9 offers, ninth refused, then drain in order
    for (int i = 0; i < 9; i++) step(1'b1, 32'h1000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
    check("full_after_8", 64'(fetch_stall), 64'd1);
    idle(9);

    // full with simultaneous push and pop: refused, then accepted
    for (int i = 0; i < 8; i++) step(1'b1, 32'h2000 + 32'(i), 32'h100 + 32'(i * 4), 1'b1, 1'b0);
    step(1'b1, 32'h2008, 32'h120, 1'b0, 1'b0);
    check("count_after_refuse", 64'(count), 64'd7);
    step(1'b1, 32'h2009, 32'h124, 1'b1, 1'b0);
    check("count_after_accept", 64'(count), 64'd8);
    idle(9);

    // clear with simultaneous push at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 32'h3000 + 32'(i), 32'h200 + 32'(i * 4), 1'b1, 1'b0);
    step(1'b1, 32'h3005, 32'h214, 1'b0, 1'b1);
    check("count_after_clear", 64'(count), 64'd0);
    idle(1);

    // sustained push+pop across two pointer wraps
    for (int i = 0; i < 3; i++) step(1'b1, 32'h4000 + 32'(i), 32'h300 + 32'(i * 4), 1'b1, 1'b0);
    for (int i = 3; i < 23; i++) step(1'b1, 32'h4000 + 32'(i), 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    idle(4);

    // reset mid-operation at count 6
    for (int i = 0; i < 6; i++) step(1'b1, 32'h5000 + 32'(i), 32'h400 + 32'(i * 4), 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h5006, 32'h418, 1'b1, 1'b0);
    rst = 1'b0;
    check("count_after_rst", 64'(count), 64'd0);
    check("stall_after_rst", 64'(fetch_stall), 64'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(1'b1 & ($urandom_range(0, 3) != 0), $urandom, 32'(i * 4),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
    end
    rst = 1'b0;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 The block SHALL expose fetch_write  in  1  fetch offers an instruction this cycle.
REQ-003 The block SHALL expose fetch_inst  in  `Inst_Width  offered instruction word.
REQ-004 The block SHALL expose fetch_pc  in  `Inst_Addr_Width  PC of the offered instruction.
REQ-005 The block SHALL expose fetch_stall  out  1  queue full; the offer is refused.
REQ-006 The block SHALL expose inst_in  out  `Inst_Width  head instruction presented to the decoder.
REQ-007 The block SHALL expose inst_pc  out  `Inst_Addr_Width  PC of the head instruction.
REQ-008 The block SHALL expose inst_enable  out  1  head is valid and is consumed this cycle.
REQ-009 The block SHALL expose inst_stall  in  1  decoder cannot accept (driven from the decoder's pc_stall).
REQ-010 The block SHALL expose clear  in  1  flush on branch mispredict or redirect.
REQ-011 The block SHALL expose count  out  `Inst_Queue_Ptr_Width+1  current occupancy.

Function
REQ-012 Storage SHALL be a circular buffer of `Inst_Queue_Depth (8) entries, each entry {inst, pc}, with head and tail pointers of `Inst_Queue_Ptr_Width (3) bits that wrap from 7 to 0.
REQ-013 fetch_stall SHALL equal (count == `Inst_Queue_Depth), taken from registered state with no look-ahead on a same-cycle pop.
REQ-014 A push SHALL occur when fetch_write && !fetch_stall && !clear: entry[tail] <= {fetch_inst, fetch_pc}; tail <= tail+1.
REQ-015 inst_enable SHALL equal (count != 0) && !inst_stall && !clear; inst_in/inst_pc SHALL show entry[head] combinationally; when empty they SHALL be 0.
REQ-016 A pop SHALL occur exactly when inst_enable is 1: head <= head+1.
REQ-017 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-018 Full with pop in the same cycle: the push SHALL be refused (fetch_stall=1) and count SHALL drop by 1.
REQ-019 Empty with push, no bypass: the instruction SHALL appear at inst_in with inst_enable=1 in the next cycle (latency 1).
REQ-020 clear SHALL dominate: head, tail and count SHALL be set to 0 at the edge, push and pop SHALL be suppressed, and inst_enable SHALL be 0 in that cycle.
REQ-021 While inst_stall=1, the head SHALL stay stable and pushes SHALL continue until full.
REQ-022 Order SHALL be strict FIFO; no entry is lost or duplicated across wrap-around.

Reset
REQ-023 rst SHALL set head=0, tail=0 and count=0, giving fetch_stall=0, inst_enable=0, inst_in=0 and inst_pc=0 the cycle after the reset edge; rst SHALL override clear and push.
REQ-024 Reset mid-operation SHALL discard all entries; entry contents need not be cleared.

Configuration
REQ-025 Macro INST_QUEUE_BYPASS_EN SHALL enable the empty-queue bypass: when count==0, fetch_write=1, inst_stall=0 and clear=0, inst_in/inst_pc SHALL equal fetch_inst/fetch_pc and inst_enable SHALL be 1 in the same cycle, with nothing stored (count stays 0).
REQ-026 Without INST_QUEUE_BYPASS_EN, the latency SHALL always be 1 cycle per REQ-019.
REQ-027 When bypass is enabled and inst_stall=1 while empty, the offer SHALL be stored normally.

Structure
REQ-028 `Inst_Queue_Depth and `Inst_Queue_Ptr_Width SHALL live in shared defines.v beside `Inst_Width and `Inst_Addr_Width.
REQ-029 The block SHALL be a single module with no sub-module; the storage SHALL be a reg array inferred as distributed RAM.

Verification
REQ-030 Push 0x00000013 @pc 0x0, inst_stall=0 -> next cycle inst_in=0x00000013, inst_pc=0x0, inst_enable=1; in the following cycle count=0. With bypass: same-cycle output and count stays 0.
REQ-031 inst_stall=1, push 9 instructions @pc 0x0..0x20 -> fetch_stall=1 after the 8th; the 9th is refused; release the stall -> pcs 0x0..0x1C emerge in order, one per cycle.
REQ-032 Full queue, fetch_write=1 and pop in the same cycle -> push refused, count 8->7; the next cycle the push is accepted and count=8.
REQ-033 count=5, clear=1 with a simultaneous push -> next cycle count=0 and inst_enable=0; clear-cycle inst_enable=0.
REQ-034 Sustained push+pop over 20 instructions (pointer wrap twice) -> outputs match the input sequence exactly and count stays constant.
REQ-035 rst asserted with count=6 -> next cycle count=0, fetch_stall=0, inst_enable=0.
